// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline stage.
// The skid-buffer state type is only consumed when PIPE_STAGE_SKID_EN is defined.
package pipe_pkg;

    localparam int unsigned PIPE_OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_data_slot.sv
// Single payload register: clear to RESET_VAL has priority over load.
module pipe_data_slot #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Payload storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= RESET_VAL;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : pipe_data_slot

// File: rtl/pipe_stage_hs.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and
// configurable bubble value. Define PIPE_STAGE_SKID_EN to add a skid slot so
// that in_ready is registered (no combinational path from out_ready).
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter bit               ZERO_BUBBLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    logic             main_load;
    logic             main_clr;
    logic [WIDTH-1:0] main_d;

`ifdef PIPE_STAGE_SKID_EN

    pipe_state_t      state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_load;
    logic             main_sel_skid;
    logic             xfer_in;
    logic             xfer_out;
    logic [WIDTH-1:0] skid_q;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign xfer_in   = in_valid & in_ready_q;
    assign xfer_out  = out_valid_q & out_ready;
    assign main_d    = main_sel_skid ? skid_q : in_data;
    assign occupancy = PIPE_OCC_W'(state_q);

    // Next-state and slot control for the main/skid buffer pair.
    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        main_clr      = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (xfer_in) begin
                    state_d   = ST_BUSY;
                    main_load = 1'b1;
                end
            end
            ST_BUSY: begin
                if (xfer_in && xfer_out) begin
                    main_load = 1'b1;
                end else if (xfer_in) begin
                    state_d   = ST_FULL;
                    skid_load = 1'b1;
                end else if (xfer_out) begin
                    state_d  = ST_EMPTY;
                    main_clr = ZERO_BUBBLE;
                end
            end
            ST_FULL: begin
                if (xfer_out) begin
                    state_d       = ST_BUSY;
                    main_load     = 1'b1;
                    main_sel_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Squash wins over any transfer-in this cycle.
        if (flush) begin
            state_d   = ST_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    pipe_data_slot #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid_slot (
        .clk    (clk),
        .clr_i  (rst | flush),
        .load_i (skid_load),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

`else

    logic out_valid_q, out_valid_d;

    assign out_valid = out_valid_q;
    assign in_ready  = ~out_valid_q | out_ready;
    assign main_d    = in_data;
    assign occupancy = {1'b0, out_valid_q};

    // Single-register stage: advance whenever the slot is free or draining.
    always_comb begin
        out_valid_d = out_valid_q;
        main_load   = 1'b0;
        main_clr    = 1'b0;
        if (in_ready) begin
            out_valid_d = in_valid;
            main_load   = in_valid;
            main_clr    = ~in_valid & ZERO_BUBBLE;
        end
        // Squash wins over any transfer-in this cycle.
        if (flush) begin
            out_valid_d = 1'b0;
            main_load   = 1'b0;
        end
    end

    // Output valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

`endif

    pipe_data_slot #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main_slot (
        .clk    (clk),
        .clr_i  (rst | flush | main_clr),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (out_data)
    );

endmodule : pipe_stage_hs
